piso_bit_serializer: RTL and testbench

- Parallel-in/serial-out stage feeding the Moore "101" sequence detector's 1-bit `in` port.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clk.
- Back-to-back words produce a gap-free bit stream, so patterns that span a word boundary still reach the detector intact.

---
 rtl/piso_bit_serializer.sv | 138 +++++++++++++
 tb/tb_piso_bit_serializer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// piso_bit_serializer
//
// Parallel-in/serial-out stage that feeds a 1-bit sequence detector. Words of
// WIDTH bits are accepted over a valid/ready handshake and shifted out
// MSB-first, one bit per clock. A word may be accepted on the final bit of the
// previous frame, so back-to-back words form a gap-free bit stream.
//
// Optional feature (macro PISO_PARITY_EN):
//   Defined   - an even-parity bit (XOR of the captured word) follows the data
//               bits, so each frame is WIDTH+1 bits long.
//   Undefined - each frame is exactly WIDTH bits and no parity state exists.
//
// Parameters:
//   WIDTH       data bits per word (2..32)
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous reset, active low
//   load_valid  upstream presents a word on load_data
//   load_ready  serializer accepts a word on this cycle's rising edge
//   load_data   word to serialize, sampled only on a handshake
//   ser_out     serial bit stream (MSB first)
//   ser_valid   ser_out carries a frame bit this cycle
//   last_bit    ser_out is the final bit of the current frame
//   busy        a frame is being shifted out
// -----------------------------------------------------------------------------
module piso_bit_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 2);
`ifdef PISO_PARITY_EN
    localparam int FRAME_LEN = WIDTH + 1;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic             w_ready;
    logic             w_hs;
    logic             w_shifting;

`ifdef PISO_PARITY_EN
    logic             r_par;

    function automatic logic even_parity(input logic [WIDTH-1:0] word);
        even_parity = ^word;
    endfunction
`endif

    // Handshake and next-state decode, all from registered state. load_ready
    // is gated by rst so it drops immediately while reset is held.
    always_comb begin
        w_shifting  = (r_state == S_SHIFT);
        w_last      = w_shifting && (r_cnt == LAST_CNT);
        w_ready     = rst && ((r_state == S_IDLE) || w_last);
        w_hs        = load_valid && w_ready;
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // A handshake on the last bit keeps us in SHIFT for the next frame.
                if (w_last && !w_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_hs) begin
            r_shift <= load_data;
            r_cnt   <= '0;
        end else if (w_shifting) begin
            r_shift <= r_shift << 1;
            // Park the counter at zero when the frame ends so it never wraps.
            r_cnt   <= w_last ? '0 : (r_cnt + CNT_W'(1));
        end
    end

`ifdef PISO_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_par <= 1'b0;
        end else if (w_hs) begin
            r_par <= even_parity(load_data);
        end
    end

    // The parity bit replaces the (already emptied) shift register on the last bit.
    assign ser_out = w_shifting && (w_last ? r_par : r_shift[WIDTH-1]);
`else
    assign ser_out = w_shifting && r_shift[WIDTH-1];
`endif

    assign load_ready = w_ready;
    assign ser_valid  = w_shifting;
    assign busy       = w_shifting;
    assign last_bit   = w_last;

endmodule

// File: tb/tb_piso_bit_serializer.sv
// -----------------------------------------------------------------------------
// Testbench for piso_bit_serializer. A queue of expected frame bits is the
// reference: each accepted word appends its bits (plus parity when
// PISO_PARITY_EN is defined), and one bit is consumed per clock.
// -----------------------------------------------------------------------------
module tb_piso_bit_serializer;

    localparam int WIDTH = 8;
`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_valid = 1'b0;
    logic [WIDTH-1:0] load_data = '0;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             last_bit;
    logic             busy;

    int n_chk  = 0;
    int n_pass = 0;
    bit exp_q[$];

    piso_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .last_bit   (last_bit),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (exp_q.size() > 0);
        check("ser_valid",  32'(ser_valid),  32'(v));
        check("ser_out",    32'(ser_out),    v ? 32'(exp_q[0]) : 32'd0);
        check("last_bit",   32'(last_bit),   32'(exp_q.size() == 1));
        check("busy",       32'(busy),       32'(v));
        check("load_ready", 32'(load_ready), 32'(rst && (exp_q.size() <= 1)));
    endtask

    // Called just after a falling edge: drive inputs, advance the model across
    // the next rising edge, then check outputs at the following falling edge.
    task automatic cycle(input bit v, input logic [WIDTH-1:0] d, output bit accepted);
        bit hs;
        load_valid = v;
        load_data  = d;
        hs = v && rst && (exp_q.size() <= 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (hs) begin
            for (int i = WIDTH - 1; i >= 0; i--) exp_q.push_back(d[i]);
`ifdef PISO_PARITY_EN
            exp_q.push_back(^d);
`endif
        end
        accepted = hs;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic send(input logic [WIDTH-1:0] d);
        bit acc;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) cycle(1'b1, d, acc);
        if (!acc) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, WIDTH'($urandom), acc);
    endtask

    initial begin
        bit acc;
        bit pend;
        logic [WIDTH-1:0] pd;

        // Reset state, with load_valid held high during reset.
        load_valid = 1'b1;
        load_data  = 8'hC3;
        #1;
        check_outputs();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hC3, acc);
        rst = 1'b1;
        #1;
        check_outputs();
        idle(2);

        // Single word 8'hA5.
        send(8'hA5);
        idle(FLEN + 2);

        // Back-to-back 8'hA5 then 8'h5A.
        send(8'hA5);
        send(8'h5A);
        idle(FLEN + 2);

        // 8'hFF presented mid-frame must wait for the last bit of 8'h00.
        send(8'h00);
        send(8'hFF);
        idle(FLEN + 2);

        // Parity-relevant words.
        send(8'h07);
        idle(FLEN + 1);
        send(8'h03);
        idle(FLEN + 1);

        // Reset asserted mid-frame of 8'h81, between clock edges.
        send(8'h81);
        idle(3);
        #2;
        rst = 1'b0;
        exp_q.delete();
        #1;
        check_outputs();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'hFF, acc);
        load_valid = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs();
        idle(FLEN + 2);

        // Randomized traffic; a pending word is held until accepted.
        pend = 1'b0;
        pd   = '0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && ($urandom_range(0, 2) != 0)) begin
                pend = 1'b1;
                pd   = WIDTH'($urandom);
            end
            cycle(pend, pend ? pd : WIDTH'($urandom), acc);
            if (acc) pend = 1'b0;
        end
        idle(FLEN + 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
